// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 front end: word width, canonical NOP and fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFault
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold, flush the valid bit, or reset to a NOP.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= in_instr;
      pc       <= in_pc;
      pc_plus4 <= in_pc + 32'd4;
    end else if (flush) begin
      // Flush only drops the valid bit; payload is left stale.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, redirects, backpressure from decode and sticky fetch faults.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_INST = 64
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_last_byte;
  logic            redir_act;
  logic            misaligned;
  logic            slot_free;
  logic            range_fault;
  logic            run_ok;
  logic            load;
  logic            flush;

  assign imem_addr    = pc;
  assign pc_next      = pc + 32'd4;
  assign pc_last_byte = pc + 32'd3;

  // Redirects are dead once the fetch unit has faulted.
  assign redir_act   = redirect_valid && (state != StFault);
  assign misaligned  = redirect_pc[1:0] != 2'b00;
  assign slot_free   = !id_valid || id_ready;
  assign range_fault = pc_last_byte >= NUM_INST;
  assign run_ok      = (state == StRun) && !redir_act && slot_free;
  assign load        = run_ok && !range_fault;
  assign flush       = redir_act || (id_valid && id_ready && !load);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      case (state)
        StIdle: state <= StRun;
        StRun: begin
          if (load) begin
            pc <= pc_next;
          end else if (run_ok && range_fault) begin
            state    <= StFault;
            fault    <= 1'b1;
            fault_pc <= pc;
          end
        end
        StFault: ;
        default: state <= StIdle;
      endcase
      // Redirect wins over sequencing, including the IDLE -> RUN step.
      if (redir_act) begin
        if (misaligned) begin
          state    <= StFault;
          fault    <= 1'b1;
          fault_pc <= redirect_pc;
        end else begin
          pc <= redirect_pc;
        end
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (flush),
    .in_instr (imem_rdata),
    .in_pc    (pc),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc       (id_pc),
    .pc_plus4 (id_pc_plus4)
  );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction.
REQ-002 SHALL have parameter NUM_INST, default 64, instruction-memory depth in bytes.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_addr  out  32  byte address driven to instruction memory (= current PC).
REQ-006 imem_rdata  in  32  little-endian instruction word returned combinationally for imem_addr.
REQ-007 redirect_valid  in  1  taken branch/jump from execute, one-cycle pulse.
REQ-008 redirect_pc  in  32  redirect target byte address.
REQ-009 id_ready  in  1  decode accepts the IF/ID entry this cycle.
REQ-010 id_valid  out  1  IF/ID entry valid.
REQ-011 id_instr  out  32  fetched instruction.
REQ-012 id_pc  out  32  address of id_instr.
REQ-013 id_pc_plus4  out  32  id_pc + 4, mod 2^32.
REQ-014 fault  out  1  sticky fetch fault.
REQ-015 fault_pc  out  32  offending address.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FAULT; IDLE -> RUN unconditionally after one cycle; RUN -> FAULT on a fault condition; FAULT exits only on rst.
REQ-017 imem_addr SHALL equal the PC register in every state.
REQ-018 Capture condition: state RUN, no redirect, no fault condition, and (!id_valid || id_ready).
REQ-019 On capture: id_instr <= imem_rdata, id_pc <= pc, id_pc_plus4 <= pc+4, id_valid <= 1, pc <= pc+4; instruction at PC appears on id_* one cycle after the capture edge.
REQ-020 Stall (id_valid && !id_ready, no redirect): PC and all id_* SHALL hold unchanged.
REQ-021 id_valid && id_ready with no capture possible SHALL clear id_valid.
REQ-022 Redirect has priority over capture and stall: id_valid <= 0 (flush), pc <= redirect_pc, no capture that cycle.
REQ-023 Redirect in IDLE SHALL be honoured (pc updated); in FAULT it SHALL be ignored.
REQ-024 Fault condition A: redirect_valid with redirect_pc[1:0] != 0 -> FAULT, fault_pc <= redirect_pc, id_valid <= 0.
REQ-025 Fault condition B: in RUN, capture otherwise permitted and pc+3 >= NUM_INST -> FAULT, fault_pc <= pc, no capture.
REQ-026 In FAULT: no captures; a held valid entry SHALL remain until id_ready, then id_valid <= 0; fault stays 1.
REQ-027 PC arithmetic SHALL be 32-bit unsigned, wrapping mod 2^32; out-of-range addresses are caught by REQ-025 before use.

Reset
REQ-028 On rst: state IDLE, pc = RESET_PC, imem_addr = RESET_PC, id_valid = 0, id_instr = 32'h0000_0013 (NOP), id_pc = 0, id_pc_plus4 = 0, fault = 0, fault_pc = 0.
REQ-029 rst asserted mid-operation SHALL override redirect, stall, and FAULT in the same edge.

Structure
REQ-030 Shared package riscv_pkg SHALL hold XLEN = 32, NOP_INSTR = 32'h0000_0013, and the fetch_state_t enum.
REQ-031 The IF/ID register (load, hold, flush, reset-to-NOP) SHALL be a sub-module if_id_reg; PC, FSM, and fault logic SHALL stay in fetch_stage.

Verification (memory preloaded: 0x0 = 0x00000033, 0x4 = 0x40000033, 0x8 = 0x00006033)
REQ-032 Release rst, id_ready = 1 -> one IDLE cycle, then id_pc = 0, 4, 8 on consecutive cycles with id_instr = 0x00000033, 0x40000033, 0x00006033.
REQ-033 id_ready = 0 for 3 cycles while id_pc = 8 -> id_* hold, imem_addr stays 0xC; id_ready = 1 -> id_pc = 0xC next cycle.
REQ-034 Redirect to 0x20 during a stall -> next cycle id_valid = 0, imem_addr = 0x20; following cycle id_pc = 0x20.
REQ-035 Redirect to 0x22 -> fault = 1, fault_pc = 0x22, id_valid = 0 thereafter, and later redirects are ignored.
REQ-036 Sequential run with NUM_INST = 64 -> last id_pc = 0x3C, then fault = 1, fault_pc = 0x40.
REQ-037 rst pulsed while in FAULT with a stalled valid entry -> next cycle fault = 0, id_valid = 0, imem_addr = RESET_PC, id_instr = 0x00000013.
